mult_strm_wrap: RTL and testbench

- Parametrised successor to the single-channel 64-bit multiply wrapper.
- Buffers operand pairs in an entry queue and issues them into an internal fixed-latency arithmetic pipeline with a selectable op mode.
- Results land in a result FIFO with a valid/ready output, so downstream can backpressure without losing results.
- Sits between a stream producer (push/almost-full protocol) and a stream consumer in the personality datapath.

---
 rtl/mult_strm_pkg.sv | 21 ++
 rtl/mult_strm_fifo.sv | 45 ++++
 rtl/mult_strm_pipe.sv | 69 ++++++
 rtl/mult_strm_wrap.sv | 134 +++++++++++++
 tb/tb_mult_strm_wrap.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mult_strm_pkg.sv
// Shared definitions for the streaming multiply wrapper: op encodings and sizing helper.
package mult_strm_pkg;

  typedef enum logic [1:0] {
    MUL_LO   = 2'd0,
    MUL_HI_U = 2'd1,
    MUL_HI_S = 2'd2,
    ADD      = 2'd3
  } op_e;

  localparam int unsigned OP_W = 2;

  // Smallest r with 2**r >= n.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/mult_strm_fifo.sv
// Circular FIFO with combinational head and occupancy count; caller guards push/pop.
module mult_strm_fifo
  import mult_strm_pkg::*;
#(
  parameter int unsigned DW    = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                    ck,
  input  logic                    rst,
  input  logic                    i_push,
  input  logic [DW-1:0]           i_data,
  input  logic                    i_pop,
  output logic [DW-1:0]           o_data,
  output logic [clog2(DEPTH):0]   o_count
);

  localparam int unsigned AW = clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  always_ff @(posedge ck) begin
    if (i_push) r_mem[r_wr_ptr] <= i_data;
  end

  // Power-of-two depth lets pointers wrap naturally.
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(i_push) - CW'(i_pop);
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/mult_strm_pipe.sv
// Fixed-latency arithmetic pipeline; result formed at entry, then carried LAT stages with valid/tag.
module mult_strm_pipe
  import mult_strm_pkg::*;
#(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned TAG_W = 8,
  parameter int unsigned LAT   = 4
) (
  input  logic             ck,
  input  logic             rst,
  input  logic             i_vld,
  input  op_e              i_op,
  input  logic [TAG_W-1:0] i_tag,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_vld,
  output logic [TAG_W-1:0] o_tag,
  output logic [WIDTH-1:0] o_res
);

  logic [2*WIDTH-1:0] w_a_ext;
  logic [2*WIDTH-1:0] w_b_ext;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_res;

  logic [LAT-1:0]            r_vld;
  logic [LAT-1:0][TAG_W-1:0] r_tag;
  logic [LAT-1:0][WIDTH-1:0] r_res;

  // One multiplier: sign-extend only for MUL_HI_S; low half is identical either way.
  always_comb begin
    w_a_ext = {{WIDTH{1'b0}}, i_a};
    w_b_ext = {{WIDTH{1'b0}}, i_b};
    if (i_op == MUL_HI_S) begin
      w_a_ext = {{WIDTH{i_a[WIDTH-1]}}, i_a};
      w_b_ext = {{WIDTH{i_b[WIDTH-1]}}, i_b};
    end
    w_prod = w_a_ext * w_b_ext;
    w_res  = '0;
    case (i_op)
      MUL_LO:             w_res = w_prod[WIDTH-1:0];
      MUL_HI_U, MUL_HI_S: w_res = w_prod[2*WIDTH-1:WIDTH];
      ADD:                w_res = i_a + i_b;
      default:            w_res = '0;
    endcase
  end

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      r_vld <= '0;
      r_tag <= '0;
      r_res <= '0;
    end else begin
      r_vld[0] <= i_vld;
      r_tag[0] <= i_tag;
      r_res[0] <= w_res;
      for (int i = 1; i < int'(LAT); i++) begin
        r_vld[i] <= r_vld[i-1];
        r_tag[i] <= r_tag[i-1];
        r_res[i] <= r_res[i-1];
      end
    end
  end

  assign o_vld = r_vld[LAT-1];
  assign o_tag = r_tag[LAT-1];
  assign o_res = r_res[LAT-1];

endmodule

// File: rtl/mult_strm_wrap.sv
// Streaming multiply wrapper: entry queue -> credit-gated issue -> LAT pipeline -> result FIFO.
module mult_strm_wrap
  import mult_strm_pkg::*;
#(
  parameter int unsigned WIDTH       = 64,
  parameter int unsigned TAG_W       = 8,
  parameter int unsigned ENTRY_DEPTH = 32,
  parameter int unsigned AFULLCNT    = ENTRY_DEPTH - 2,
  parameter int unsigned LAT         = 4,
  parameter int unsigned RES_DEPTH   = 8
) (
  input  logic             ck,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [1:0]       i_op,
  input  logic [TAG_W-1:0] i_tag,
  input  logic             i_vld,
  output logic             o_rdy,
  output logic [WIDTH-1:0] o_res,
  output logic [TAG_W-1:0] o_tag,
  output logic             o_vld,
  input  logic             i_res_rdy,
  output logic             o_ovf,
  output logic             o_busy
);

  localparam int unsigned QCW = clog2(ENTRY_DEPTH) + 1;
  localparam int unsigned RCW = clog2(RES_DEPTH) + 1;

  typedef struct packed {
    op_e              op;
    logic [TAG_W-1:0] tag;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } entry_t;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [WIDTH-1:0] res;
  } result_t;

  entry_t           w_q_wdata;
  entry_t           w_q_head;
  logic [QCW-1:0]   w_q_count;
  logic             w_q_empty;
  logic             w_q_full;
  logic             w_q_push;
  logic             w_issue;

  logic             w_pipe_vld;
  logic [TAG_W-1:0] w_pipe_tag;
  logic [WIDTH-1:0] w_pipe_res;
  result_t          w_r_wdata;
  result_t          w_r_head;
  logic [RCW-1:0]   w_r_count;
  logic             w_res_xfer;

  logic [RCW-1:0]   r_credit;
  logic             r_ovf;

  assign w_q_wdata = '{op: op_e'(i_op), tag: i_tag, a: i_a, b: i_b};
  assign w_q_empty = (w_q_count == '0);
  assign w_q_full  = (w_q_count == QCW'(ENTRY_DEPTH));
  assign w_issue   = !w_q_empty && (r_credit != '0);
  // A same-edge issue frees a slot, so a push at full is still accepted.
  assign w_q_push  = i_vld && (!w_q_full || w_issue);

  mult_strm_fifo #(
    .DW    ($bits(entry_t)),
    .DEPTH (ENTRY_DEPTH)
  ) u_entry_q (
    .ck      (ck),
    .rst     (rst),
    .i_push  (w_q_push),
    .i_data  (w_q_wdata),
    .i_pop   (w_issue),
    .o_data  (w_q_head),
    .o_count (w_q_count)
  );

  mult_strm_pipe #(
    .WIDTH (WIDTH),
    .TAG_W (TAG_W),
    .LAT   (LAT)
  ) u_pipe (
    .ck    (ck),
    .rst   (rst),
    .i_vld (w_issue),
    .i_op  (w_q_head.op),
    .i_tag (w_q_head.tag),
    .i_a   (w_q_head.a),
    .i_b   (w_q_head.b),
    .o_vld (w_pipe_vld),
    .o_tag (w_pipe_tag),
    .o_res (w_pipe_res)
  );

  assign w_r_wdata = '{tag: w_pipe_tag, res: w_pipe_res};

  mult_strm_fifo #(
    .DW    ($bits(result_t)),
    .DEPTH (RES_DEPTH)
  ) u_res_q (
    .ck      (ck),
    .rst     (rst),
    .i_push  (w_pipe_vld),
    .i_data  (w_r_wdata),
    .i_pop   (w_res_xfer),
    .o_data  (w_r_head),
    .o_count (w_r_count)
  );

  assign o_vld      = (w_r_count != '0);
  assign w_res_xfer = o_vld && i_res_rdy;

  // Credit = free result slots not already claimed by in-flight ops.
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      r_credit <= RCW'(RES_DEPTH);
      r_ovf    <= 1'b0;
    end else begin
      r_credit <= r_credit - RCW'(w_issue) + RCW'(w_res_xfer);
      if (i_vld && w_q_full && !w_issue) r_ovf <= 1'b1;
    end
  end

  assign o_res  = o_vld ? w_r_head.res : '0;
  assign o_tag  = o_vld ? w_r_head.tag : '0;
  assign o_ovf  = r_ovf;
  assign o_rdy  = (w_q_count < QCW'(AFULLCNT));
  assign o_busy = !w_q_empty || (r_credit != RCW'(RES_DEPTH));

endmodule

// File: tb/tb_mult_strm_wrap.sv
// Directed bench for mult_strm_wrap at default parameters (WIDTH 64, LAT 4, depths 32/8).
module tb_mult_strm_wrap;

  localparam int LAT = 4;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        ck = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] i_a = '0;
  logic [63:0] i_b = '0;
  logic [1:0]  i_op = '0;
  logic [7:0]  i_tag = '0;
  logic        i_vld = 1'b0;
  logic        o_rdy;
  logic [63:0] o_res;
  logic [7:0]  o_tag;
  logic        o_vld;
  logic        i_res_rdy = 1'b0;
  logic        o_ovf;
  logic        o_busy;

  int n_checks = 0;
  int n_fail   = 0;
  int rx_count = 0;

  logic [63:0] exp_res[$];
  logic [7:0]  exp_tag[$];
  logic        prev_stall = 1'b0;
  logic [63:0] prev_res = '0;
  logic [7:0]  prev_tag = '0;

  mult_strm_wrap dut (
    .ck        (ck),
    .rst       (rst),
    .i_a       (i_a),
    .i_b       (i_b),
    .i_op      (i_op),
    .i_tag     (i_tag),
    .i_vld     (i_vld),
    .o_rdy     (o_rdy),
    .o_res     (o_res),
    .o_tag     (o_tag),
    .o_vld     (o_vld),
    .i_res_rdy (i_res_rdy),
    .o_ovf     (o_ovf),
    .o_busy    (o_busy)
  );

  always #5 ck = ~ck;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [1:0] op, input logic [63:0] a,
                                        input logic [63:0] b);
    logic [127:0]        pu;
    logic signed [127:0] ps;
    pu = {64'd0, a} * {64'd0, b};
    ps = 128'($signed(a)) * 128'($signed(b));
    case (op)
      2'd0:    return pu[63:0];
      2'd1:    return pu[127:64];
      2'd2:    return ps[127:64];
      default: return a + b;
    endcase
  endfunction

  // One cycle, entered and left at a negedge: check the presented head, then drive inputs.
  task automatic step(input logic push, input logic [1:0] op, input logic [63:0] a,
                      input logic [63:0] b, input logic [7:0] tag, input logic rdy,
                      input logic accept, input logic [63:0] er);
    i_res_rdy = rdy;
    if (o_vld) begin
      if (exp_res.size() == 0) begin
        chk("spurious_vld", 64'(o_vld), 64'd0);
      end else begin
        chk("res", o_res, exp_res[0]);
        chk("tag", 64'(o_tag), 64'(exp_tag[0]));
        if (rdy) begin
          void'(exp_res.pop_front());
          void'(exp_tag.pop_front());
          rx_count++;
        end
      end
      if (prev_stall) begin
        chk("stall_res_stable", o_res, prev_res);
        chk("stall_tag_stable", 64'(o_tag), 64'(prev_tag));
      end
    end
    prev_stall = o_vld && !rdy;
    prev_res   = o_res;
    prev_tag   = o_tag;
    i_vld = push;
    i_op  = op;
    i_a   = a;
    i_b   = b;
    i_tag = tag;
    if (push && accept) begin
      exp_res.push_back(er);
      exp_tag.push_back(tag);
    end
    @(negedge ck);
  endtask

  task automatic drain(input int bound);
    int n;
    n = 0;
    while (exp_res.size() != 0 && n < bound) begin
      step(1'b0, 2'd0, '0, '0, '0, 1'b1, 1'b0, '0);
      n++;
    end
    chk("drain_left", 64'(exp_res.size()), 64'd0);
  endtask

  task automatic lat_test(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                          input logic [7:0] tag, input logic [63:0] er);
    int n;
    i_res_rdy = 1'b1;
    i_vld = 1'b1;
    i_op  = op;
    i_a   = a;
    i_b   = b;
    i_tag = tag;
    @(posedge ck);
    n = 1;
    @(negedge ck);
    i_vld = 1'b0;
    while (!o_vld && n < 20) begin
      @(posedge ck);
      n++;
      @(negedge ck);
    end
    chk("latency", 64'(n), 64'(LAT + 2));
    chk("lat_res", o_res, er);
    chk("lat_tag", 64'(o_tag), 64'(tag));
    @(negedge ck);
    chk("lat_popped", 64'(o_vld), 64'd0);
    chk("lat_idle", 64'(o_busy), 64'd0);
  endtask

  initial begin
    int base;
    int sent;
    int cyc;
    logic [1:0]  op;
    logic [63:0] a;
    logic [63:0] b;

    // Reset values, held in reset and after release
    repeat (3) @(negedge ck);
    chk("rst_vld", 64'(o_vld), 64'd0);
    chk("rst_busy", 64'(o_busy), 64'd0);
    chk("rst_ovf", 64'(o_ovf), 64'd0);
    chk("rst_rdy", 64'(o_rdy), 64'd1);
    chk("rst_res", o_res, 64'd0);
    chk("rst_tag", 64'(o_tag), 64'd0);
    rst = 1'b0;
    @(negedge ck);
    chk("post_rst_rdy", 64'(o_rdy), 64'd1);
    chk("post_rst_busy", 64'(o_busy), 64'd0);

    // Single MUL_LO with exact latency
    lat_test(2'd0, 64'd3, 64'd5, 8'h11, 64'd15);

    // Directed ops with hand-computed results
    step(1'b1, 2'd2, ONES, 64'd2, 8'h21, 1'b1, 1'b1, ONES);
    step(1'b1, 2'd1, ONES, 64'd2, 8'h22, 1'b1, 1'b1, 64'd1);
    step(1'b1, 2'd3, ONES, 64'd1, 8'h23, 1'b1, 1'b1, 64'd0);
    step(1'b1, 2'd0, ONES, ONES, 8'h24, 1'b1, 1'b1, 64'd1);
    step(1'b1, 2'd2, ONES, ONES, 8'h25, 1'b1, 1'b1, 64'd0);
    step(1'b1, 2'd1, 64'h8000_0000_0000_0000, 64'd4, 8'h26, 1'b1, 1'b1, 64'd2);
    step(1'b1, 2'd2, 64'h8000_0000_0000_0000, 64'd4, 8'h27, 1'b1, 1'b1, ONES - 64'd1);
    drain(40);

    // 100 back-to-back random ops, one result per cycle once filled
    base = rx_count;
    for (int i = 0; i < 100; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = {$urandom, $urandom};
      b  = {$urandom, $urandom};
      if (i >= LAT + 2) chk("thru_vld", 64'(o_vld), 64'd1);
      step(1'b1, op, a, b, 8'(i), 1'b1, 1'b1, model(op, a, b));
    end
    drain(40);
    chk("b2b_count", 64'(rx_count - base), 64'd100);

    // Backpressure: 48 pushes with consumer stalled; 8 issue, queue fills at 32
    base = rx_count;
    for (int k = 0; k < 48; k++) begin
      op = 2'($urandom_range(0, 3));
      a  = {$urandom, $urandom};
      b  = {$urandom, $urandom};
      chk("afull_rdy", 64'(o_rdy), 64'(k < 38));
      chk("ovf_sticky", 64'(o_ovf), 64'(k >= 41));
      step(1'b1, op, a, b, 8'(k), 1'b0, k < 40, model(op, a, b));
    end
    for (int k = 0; k < 10; k++) step(1'b0, 2'd0, '0, '0, '0, 1'b0, 1'b0, '0);
    chk("stalled_rdy", 64'(o_rdy), 64'd0);
    chk("stalled_busy", 64'(o_busy), 64'd1);
    drain(200);
    chk("bp_count", 64'(rx_count - base), 64'd40);
    chk("bp_ovf_held", 64'(o_ovf), 64'd1);

    // Reset with ops in flight and queued
    for (int k = 0; k < 8; k++) begin
      a = 64'(k + 2);
      step(1'b1, 2'd0, a, 64'd3, 8'(8'h80 + k), 1'b0, 1'b1, a * 64'd3);
    end
    rst = 1'b1;
    i_vld = 1'b0;
    #1;
    chk("mid_rst_vld", 64'(o_vld), 64'd0);
    chk("mid_rst_busy", 64'(o_busy), 64'd0);
    chk("mid_rst_ovf", 64'(o_ovf), 64'd0);
    chk("mid_rst_rdy", 64'(o_rdy), 64'd1);
    chk("mid_rst_res", o_res, 64'd0);
    chk("mid_rst_tag", 64'(o_tag), 64'd0);
    exp_res.delete();
    exp_tag.delete();
    prev_stall = 1'b0;
    @(negedge ck);
    rst = 1'b0;
    @(negedge ck);
    for (int k = 0; k < 12; k++) step(1'b0, 2'd0, '0, '0, '0, 1'b1, 1'b0, '0);
    chk("no_stale_vld", 64'(o_vld), 64'd0);
    lat_test(2'd3, 64'd7, 64'd9, 8'h33, 64'd16);

    // Random consumer stalls with producer honouring o_rdy
    base = rx_count;
    sent = 0;
    cyc  = 0;
    while ((sent < 60 || exp_res.size() != 0) && cyc < 3000) begin
      op = 2'($urandom_range(0, 3));
      a  = {$urandom, $urandom};
      b  = {$urandom, $urandom};
      if (sent < 60 && o_rdy) begin
        step(1'b1, op, a, b, 8'(sent), 1'($urandom_range(0, 1)), 1'b1, model(op, a, b));
        sent++;
      end else begin
        step(1'b0, 2'd0, '0, '0, '0, 1'($urandom_range(0, 1)), 1'b0, '0);
      end
      cyc++;
    end
    chk("rand_left", 64'(exp_res.size()), 64'd0);
    chk("rand_count", 64'(rx_count - base), 64'd60);
    chk("rand_ovf", 64'(o_ovf), 64'd0);
    i_res_rdy = 1'b1;
    @(negedge ck);
    chk("final_idle", 64'(o_busy), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
